uart_key_rx: RTL and testbench
==============================

Name: uart_key_rx

Overview:
- Receive-side counterpart of the key-state uplink: reassembles key_down frames arriving as a UART byte stream and reproduces the 40-bit key vector at the receiver.
- Sits between the uart block's read_data/read_done outputs and any consumer of key state, e.g. a sound or LED board, or loopback checking on the same board.
- Validates header, length and XOR checksum, and drops partial frames after an inter-byte timeout.

Parameters:
- KEYS, 40, key vector width; must be a multiple of 8; NBYTES = KEYS/8.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 240000, maximum clk cycles allowed between bytes of one frame (10 ms at 24 MHz).

Ports:
- clk  in  1  system clock (clk24 domain).
- rst  in  1  synchronous reset, active-high.
- read_data  in  8  received byte from uart.
- read_done  in  1  byte-ready from uart; level, may stay high for several cycles.
- key_state  out  KEYS  key vector from the last good frame; bit i = key i down.
- frame_valid  out  1  one-cycle pulse when key_state is updated.
- crc_err  out  1  one-cycle pulse on checksum mismatch.
- timeout  out  1  one-cycle pulse when a partial frame is dropped.
- err_cnt  out  8  saturating count of crc_err plus timeout events.
- busy  out  1  high while not in HUNT.

Behaviour:
- Reset (rst high at a clk edge): state=HUNT, key_state=0, shadow=0, idx=0, acc=0, gap=0, err_cnt=0, all pulses 0, busy=0, read_done_q=0.
  - Reset mid-frame discards the partial frame; key_state is also cleared.
- Byte strobe: acc_byte = read_done & ~read_done_q, where read_done_q is read_done registered.
  - Exactly one byte is accepted per rising edge of read_done, however long the level is held.
  - read_data is sampled in the strobe cycle.
- Frame format, in order:
  - HEADER
  - NBYTES data bytes, byte k carrying key bits [8k+7:8k], LSB byte first
  - checksum = XOR of all data bytes (header excluded)
- State HUNT:
  - On a strobe with byte==HEADER: go to DATA, idx=0, acc=0.
  - Any other byte is ignored silently.
- State DATA, on each strobe:
  - shadow[8*idx+:8]=byte, acc^=byte.
  - If idx==NBYTES-1, go to CHECK; otherwise idx+1.
  - A byte equal to HEADER is treated as data (no resync inside a frame).
- State CHECK, on a strobe, then return to HUNT:
  - byte==acc: key_state<=shadow and frame_valid=1, both in the cycle after the strobe (latency 1).
  - Otherwise: crc_err=1 the next cycle, err_cnt+1 saturating at 255, key_state unchanged.
- Gap counter (DATA/CHECK only):
  - gap clears on every strobe and otherwise increments.
  - When gap reaches TIMEOUT-1 with no strobe that cycle: return to HUNT, timeout=1 next cycle, err_cnt+1 saturating, key_state unchanged.
  - gap is held at 0 in HUNT.
- Simultaneous strobe and timeout expiry: the strobe wins, the byte is processed and gap clears.
- A strobe in the cycle CHECK returns to HUNT is evaluated by CHECK; the next frame's header needs a later strobe.
- Back-to-back frames with no idle gap are supported.
- frame_valid, crc_err and timeout are mutually exclusive and never high two consecutive cycles from one event.
- busy = (state != HUNT), registered.

Test Plan:
- Reset, then send A5 01 02 04 08 10 1F -> frame_valid one cycle after the 1F strobe; key_state=40'h1008040201; err_cnt=0.
- Send A5 01 02 04 08 10 00 -> crc_err pulse; key_state keeps its previous value; err_cnt=1. Then a good frame A5 FF 00 00 00 00 FF -> key_state=40'h00000000FF.
- Send A5 11 22, then idle TIMEOUT cycles (TIMEOUT set to 100 in the bench) -> timeout pulse ~100 cycles after the 22 strobe; busy drops; err_cnt+1. A byte arriving at gap=TIMEOUT-1 is accepted instead, with no timeout.
- Garbage 00 FF 5A before a good frame, plus read_done held high 5 cycles per byte -> garbage ignored; each byte counted once; key_state correct.
- Assert rst after A5 33 44 -> all outputs 0, state HUNT; a following good frame decodes normally. Then 300 bad-checksum frames -> err_cnt saturates at 255.

Source files
------------

// File: rtl/uart_key_rx.sv
// Reassembles key_down frames (header, key bytes LSB first, XOR checksum) from a
// UART byte stream into a KEYS-bit key vector, with checksum and gap-timeout checks.
module uart_key_rx #(
  parameter int unsigned KEYS    = 40,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 240000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      read_data,
  input  logic            read_done,
  output logic [KEYS-1:0] key_state,
  output logic            frame_valid,
  output logic            crc_err,
  output logic            timeout,
  output logic [7:0]      err_cnt,
  output logic            busy
);

  localparam int unsigned NBYTES = KEYS / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned GAP_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [KEYS-1:0]   shadow_q, shadow_d;
  logic [KEYS-1:0]   key_state_q, key_state_d;
  logic              read_done_q;
  logic              frame_valid_q, frame_valid_d;
  logic              crc_err_q, crc_err_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;
  logic              strobe;
  logic              expired;

  // read_done is a level that may be held; only its rising edge delivers a byte.
  assign strobe  = read_done & ~read_done_q;
  assign expired = (state_q != HUNT) && !strobe && (gap_q == GAP_MAX);

  // NOTE: combinational next-state logic uses blocking assignments with every
  // target defaulted first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    gap_d         = gap_q;
    shadow_d      = shadow_q;
    key_state_d   = key_state_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    timeout_d     = 1'b0;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      HUNT: begin
        gap_d = '0;
        if (strobe && (read_data == HEADER)) begin
          state_d = DATA;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      DATA: begin
        // A byte equal to HEADER is plain data here; there is no resync mid-frame.
        if (strobe) begin
          shadow_d[8*idx_q +: 8] = read_data;
          acc_d                  = acc_q ^ read_data;
          if (idx_q == IDX_LAST) state_d = CHECK;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      CHECK: begin
        if (strobe) begin
          state_d = HUNT;
          if (read_data == acc_q) begin
            key_state_d   = shadow_q;
            frame_valid_d = 1'b1;
          end else begin
            crc_err_d = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Gap tracking inside a frame; a strobe in the expiry cycle wins.
    if (state_q != HUNT) begin
      if (strobe) begin
        gap_d = '0;
      end else if (expired) begin
        state_d   = HUNT;
        gap_d     = '0;
        timeout_d = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    if ((crc_err_d || timeout_d) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;

    busy_d = (state_d != HUNT);
  end

  // NOTE: the shadow frame buffer is reset along with everything else, so a
  // reset mid-frame leaves no stale key bytes behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      acc_q         <= '0;
      gap_q         <= '0;
      shadow_q      <= '0;
      key_state_q   <= '0;
      read_done_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
      err_cnt_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      gap_q         <= gap_d;
      shadow_q      <= shadow_d;
      key_state_q   <= key_state_d;
      read_done_q   <= read_done;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      timeout_q     <= timeout_d;
      err_cnt_q     <= err_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign key_state   = key_state_q;
  assign frame_valid = frame_valid_q;
  assign crc_err     = crc_err_q;
  assign timeout     = timeout_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_key_rx.sv
// Directed bench for uart_key_rx: table of whole frames plus hand sequences for
// timeout, gap boundary, garbage, held read_done, mid-frame reset and saturation.
module tb_uart_key_rx;

  localparam int KEYS = 40;
  localparam int TO   = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      read_data;
  logic            read_done;
  logic [KEYS-1:0] key_state;
  logic            frame_valid, crc_err, timeout, busy;
  logic [7:0]      err_cnt;

  uart_key_rx #(.KEYS(KEYS), .HEADER(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .read_data(read_data), .read_done(read_done),
    .key_state(key_state), .frame_valid(frame_valid), .crc_err(crc_err),
    .timeout(timeout), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor sampled 1 time unit after each rising edge.
  int fv_cnt = 0, crc_cnt = 0, to_cnt = 0, fv_cyc = 0, to_cyc = 0;
  int overlap = 0, dbl = 0;
  logic prev_fv = 1'b0, prev_crc = 1'b0, prev_to = 1'b0;
  always @(posedge clk) begin
    #1;
    if (frame_valid) begin fv_cnt++; fv_cyc = cyc; end
    if (crc_err) crc_cnt++;
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (int'(frame_valid) + int'(crc_err) + int'(timeout) > 1) overlap++;
    if ((frame_valid && prev_fv) || (crc_err && prev_crc) || (timeout && prev_to)) dbl++;
    prev_fv = frame_valid; prev_crc = crc_err; prev_to = timeout;
  end

  int n_tests = 0, n_fail = 0;
  int last_strobe_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds read_done for 'hold' cycles, then one low cycle.
  task automatic send_byte(input logic [7:0] b, input int hold);
    read_data = b;
    read_done = 1'b1;
    @(negedge clk);
    last_strobe_cyc = cyc;
    repeat (hold - 1) @(negedge clk);
    read_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [55:0] bytes, input int hold);
    for (int i = 0; i < 7; i++) send_byte(bytes[55-8*i -: 8], hold);
  endtask

  typedef struct {
    logic [55:0]     bytes;
    int              hold;
    int              exp_fv;
    int              exp_crc;
    logic [KEYS-1:0] exp_key;
    int              exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv0, crc0, to0;
    vecs[0] = '{56'hA5_01_02_04_08_10_1F, 1, 1, 0, 40'h1008040201, 0};
    vecs[1] = '{56'hA5_01_02_04_08_10_00, 1, 0, 1, 40'h1008040201, 1};
    vecs[2] = '{56'hA5_FF_00_00_00_00_FF, 1, 1, 0, 40'h00000000FF, 1};
    vecs[3] = '{56'hA5_12_34_56_78_9A_92, 5, 1, 0, 40'h9A78563412, 1};
    vecs[4] = '{56'hA5_A5_00_00_00_00_A5, 2, 1, 0, 40'h00000000A5, 1};

    rst = 1'b1; read_done = 1'b0; read_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset key_state", 64'(key_state), 64'h0);
    check("reset pulses", {61'b0, frame_valid, crc_err, timeout}, 64'h0);
    check("reset err_cnt", 64'(err_cnt), 64'h0);
    check("reset busy", 64'(busy), 64'h0);

    for (int v = 0; v < 5; v++) begin
      fv0 = fv_cnt; crc0 = crc_cnt; to0 = to_cnt;
      send_frame(vecs[v].bytes, vecs[v].hold);
      check($sformatf("vec%0d frame_valid count", v), 64'(fv_cnt - fv0), 64'(vecs[v].exp_fv));
      check($sformatf("vec%0d crc_err count", v), 64'(crc_cnt - crc0), 64'(vecs[v].exp_crc));
      check($sformatf("vec%0d timeout count", v), 64'(to_cnt - to0), 64'h0);
      check($sformatf("vec%0d key_state", v), 64'(key_state), 64'(vecs[v].exp_key));
      check($sformatf("vec%0d err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d busy", v), 64'(busy), 64'h0);
      if (vecs[v].exp_fv != 0)
        check($sformatf("vec%0d latency", v), 64'(fv_cyc - last_strobe_cyc), 64'h0);
    end

    // Garbage before a frame, read_done held 5 cycles per byte.
    fv0 = fv_cnt; crc0 = crc_cnt;
    send_byte(8'h00, 5); send_byte(8'hFF, 5); send_byte(8'h5A, 5);
    check("garbage busy", 64'(busy), 64'h0);
    send_frame(56'hA5_01_02_04_08_10_1F, 5);
    check("garbage fv count", 64'(fv_cnt - fv0), 64'h1);
    check("garbage crc count", 64'(crc_cnt - crc0), 64'h0);
    check("garbage key_state", 64'(key_state), 64'h1008040201);

    // Timeout after a partial frame.
    to0 = to_cnt;
    send_byte(8'hA5, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    check("partial busy", 64'(busy), 64'h1);
    for (int i = 0; i < 3 * TO && to_cnt == to0; i++) @(negedge clk);
    check("timeout count", 64'(to_cnt - to0), 64'h1);
    check("timeout delay", 64'(to_cyc - last_strobe_cyc), 64'(TO));
    check("timeout busy", 64'(busy), 64'h0);
    check("timeout err_cnt", 64'(err_cnt), 64'h2);
    check("timeout key_state", 64'(key_state), 64'h1008040201);

    // A byte arriving exactly at gap = TIMEOUT-1 is accepted.
    to0 = to_cnt; fv0 = fv_cnt;
    send_byte(8'hA5, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    while (cyc < last_strobe_cyc + TO - 1) @(negedge clk);
    send_byte(8'h33, 1); send_byte(8'h44, 1); send_byte(8'h55, 1); send_byte(8'h11, 1);
    check("boundary timeout count", 64'(to_cnt - to0), 64'h0);
    check("boundary fv count", 64'(fv_cnt - fv0), 64'h1);
    check("boundary key_state", 64'(key_state), 64'h5544332211);
    check("boundary err_cnt", 64'(err_cnt), 64'h2);

    // Reset mid-frame.
    send_byte(8'hA5, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset key_state", 64'(key_state), 64'h0);
    check("midreset err_cnt", 64'(err_cnt), 64'h0);
    check("midreset busy", 64'(busy), 64'h0);
    check("midreset pulses", {61'b0, frame_valid, crc_err, timeout}, 64'h0);
    fv0 = fv_cnt;
    send_frame(56'hA5_01_02_04_08_10_1F, 1);
    check("postreset fv count", 64'(fv_cnt - fv0), 64'h1);
    check("postreset key_state", 64'(key_state), 64'h1008040201);

    // err_cnt saturation.
    crc0 = crc_cnt;
    for (int i = 0; i < 300; i++) send_frame(56'hA5_00_00_00_00_00_01, 1);
    check("sat crc count", 64'(crc_cnt - crc0), 64'd300);
    check("sat err_cnt", 64'(err_cnt), 64'd255);
    check("sat key_state", 64'(key_state), 64'h1008040201);

    repeat (2) @(negedge clk);
    check("pulse overlap", 64'(overlap), 64'h0);
    check("pulse double", 64'(dbl), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
